// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants: datapath width, divider state codes
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_FIN  = 2'd2;

  localparam logic [ALU_WIDTH-1:0] ALL_ONES = {ALU_WIDTH{1'b1}};

endpackage

// File: rtl/sub_step.sv
// rtl/sub_step.sv - combinational subtract step a + ~b + 1 with borrow out
// Kept as the single arithmetic unit so a faster adder can be dropped in later.
module sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);

  assign diff   = a + ~b + {{WIDTH{1'b0}}, 1'b1};
  assign borrow = diff[WIDTH];

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative unsigned restoring divider, one quotient bit per cycle
// Results and div_by_zero hold until the next accepted start.
module div_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             diff_msb_unused;

  // The shifted partial remainder needs one extra bit before the compare.
  assign r_shift = {r_q, q_q[WIDTH-1]};

  sub_step #(.WIDTH(WIDTH)) u_sub_step (
    .a      (r_shift),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  // A non-borrowing result is below the divisor, so its top bit is always zero.
  assign diff_msb_unused = diff[WIDTH];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      DIV_IDLE: begin
        // done_q blocks an accept in the cycle of the done pulse.
        if (start && !done_q) begin
          dvs_d   = divisor;
          q_d     = dividend;
          r_d     = '0;
          count_d = CW'(WIDTH);
          busy_d  = 1'b1;
          zero_d  = (divisor == '0);
          state_d = (divisor == '0) ? DIV_FIN : DIV_RUN;
        end
      end
      DIV_RUN: begin
        r_d     = borrow ? r_shift[WIDTH-1:0] : diff[WIDTH-1:0];
        q_d     = {q_q[WIDTH-2:0], ~borrow};
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          state_d = DIV_FIN;
          busy_d  = 1'b0;
        end
      end
      DIV_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DIV_IDLE;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end else begin
          quot_d = q_q;
          rem_d  = r_q;
          dbz_d  = 1'b0;
        end
      end
      default: begin
        state_d = DIV_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      count_q <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed vector bench for div_seq
module tb_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  div_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int overlap_seen = 0;

  always @(negedge clk) begin
    if (busy === 1'b1 && done === 1'b1) overlap_seen++;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 32'd3;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = (busy === 1'b1) ? 1 : 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done === 1'b1) break;
      if (busy === 1'b1) bcnt++;
    end
  endtask

  vec_t vecs[7];
  int   lat;
  int   bcnt;
  int   saw_done;

  initial begin
    vecs[0] = '{a: 32'd100,        b: 32'd7,          q: 32'd14,         r: 32'd2, dz: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          q: 32'hFFFF_FFFF,  r: 32'd0, dz: 1'b0};
    vecs[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  q: 32'd1,          r: 32'd0, dz: 1'b0};
    vecs[3] = '{a: 32'd3,          b: 32'd10,         q: 32'd0,          r: 32'd3, dz: 1'b0};
    vecs[4] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0, dz: 1'b0};
    vecs[5] = '{a: 32'd5,          b: 32'd0,          q: 32'hFFFF_FFFF,  r: 32'd5, dz: 1'b1};
    vecs[6] = '{a: 32'd9,          b: 32'd3,          q: 32'd3,          r: 32'd0, dz: 1'b0};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quotient, 32'd0);
    check("reset_remainder", remainder, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, vecs[i].dz ? 32'd1 : 32'd33);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].dz ? 32'd1 : 32'd32);
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_quotient_held", i), quotient, vecs[i].q);
    end

    // Extra starts mid-run and in the done cycle must be dropped.
    launch(32'd1000, 32'd10);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) begin
        start = 1'b1; dividend = 32'd7; divisor = 32'd7;
      end else if (lat == 11) begin
        start = 1'b0;
      end
      if (done === 1'b1) break;
    end
    check("ign_latency", lat, 32'd33);
    check("ign_quotient", quotient, 32'd100);
    check("ign_remainder", remainder, 32'd0);
    start = 1'b1; dividend = 32'd7; divisor = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_done_cycle_busy", {31'd0, busy}, 32'd0);
    check("ign_done_cycle_done", {31'd0, done}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("ign_hold_quotient", quotient, 32'd100);
    check("ign_hold_busy", {31'd0, busy}, 32'd0);

    // Reset mid-run aborts with no done pulse.
    launch(32'd1000, 32'd10);
    repeat (14) @(posedge clk);
    #1;
    check("hold_during_run_quotient", quotient, 32'd100);
    check("run_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_quotient", quotient, 32'd0);
    check("abort_remainder", remainder, 32'd0);
    check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    saw_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) saw_done++;
    end
    check("abort_no_done", saw_done, 32'd0);

    launch(32'd20, 32'd6);
    wait_done(lat, bcnt);
    check("post_abort_latency", lat, 32'd33);
    check("post_abort_quotient", quotient, 32'd3);
    check("post_abort_remainder", remainder, 32'd2);

    // rst and start together: start is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 32'd8; divisor = 32'd2;
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) saw_done++;
    end
    check("rst_start_dropped", saw_done, 32'd0);
    check("rst_start_quotient", quotient, 32'd0);

    check("busy_done_overlap", overlap_seen, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
